mem_bus_arbiter: RTL and testbench

- Shares the single-port data RAM between two requesters: master 0 (CPU load/store path) and master 1 (UART monitor/loader).
- Sits between `u_cpu`/UART monitor and `u_ram` inside `computer`.
- Uses a req/gnt/rvalid handshake, one transaction in flight, and round-robin or fixed CPU-priority arbitration.
- Gives the CPU a path to RAM that the debug/loader master cannot corrupt or starve.

---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/mem_bus_arbiter_if.sv | 50 +++++
 rtl/mem_bus_arbiter_rr_arbiter2.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the data-RAM bus arbiter: widths, arbitration modes
// and the transaction FSM state encoding.
package mem_bus_arbiter_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 8;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ACCESS    = 2'd1,
        ARB_READ_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters (CPU, UART loader), the arbiter and
// the single-port data RAM.
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
);

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter side: consumes requests and RAM read data, drives grants and RAM controls.
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Combinational two-way grant: round-robin on last_owner, or fixed priority
// to requester 0. At most one grant, and none while i_en is low.
module rr_arbiter2
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic ARB_MODE = ARB_RR
) (
    input  logic i_en,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    output logic o_gnt0,
    output logic o_gnt1
);

    // Grant selection; a tie in round-robin mode goes to whoever did not own the bus last.
    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_en) begin
            if (i_req0 && i_req1) begin
                if (ARB_MODE == ARB_FIXED) begin
                    o_gnt0 = 1'b1;
                end else if (i_last_owner) begin
                    o_gnt0 = 1'b1;
                end else begin
                    o_gnt1 = 1'b1;
                end
            end else if (i_req0) begin
                o_gnt0 = 1'b1;
            end else if (i_req1) begin
                o_gnt1 = 1'b1;
            end else begin
                o_gnt0 = 1'b0;
                o_gnt1 = 1'b0;
            end
        end else begin
            o_gnt0 = 1'b0;
            o_gnt1 = 1'b0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port data RAM between the CPU (master 0) and the UART
// monitor/loader (master 1), one transaction in flight at a time.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int   ADDR_W   = ADDR_WIDTH,
    parameter int   DATA_W   = DATA_WIDTH,
    parameter logic ARB_MODE = ARB_RR
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus,
    output logic               busy
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    logic w_idle;
    logic w_gnt0;
    logic w_gnt1;
    logic w_accept;
    logic w_rd_valid;

    // Reset is gated in so that no grant, write strobe or rvalid escapes in the reset cycle.
    assign w_idle     = (r_state == ARB_IDLE) && !reset;
    assign w_accept   = w_gnt0 || w_gnt1;
    assign w_rd_valid = (r_state == ARB_READ_WAIT) && !reset;

    rr_arbiter2 #(
        .ARB_MODE (ARB_MODE)
    ) u_rr_arbiter2 (
        .i_en         (w_idle),
        .i_req0       (bus.m0_req),
        .i_req1       (bus.m1_req),
        .i_last_owner (r_last_owner),
        .o_gnt0       (w_gnt0),
        .o_gnt1       (w_gnt1)
    );

    // Transaction FSM next state: ACCESS and READ_WAIT each last exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ARB_ACCESS;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_ACCESS: begin
                if (r_we) begin
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_state_nxt = ARB_READ_WAIT;
                end
            end
            ARB_READ_WAIT: w_state_nxt = ARB_IDLE;
            default:       w_state_nxt = ARB_IDLE;
        endcase
    end

    // State register plus the request latch captured on the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= {ADDR_W{1'b0}};
            r_wdata      <= {DATA_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner      <= w_gnt1;
                r_last_owner <= w_gnt1;
                r_we         <= w_gnt1 ? bus.m1_we    : bus.m0_we;
                r_addr       <= w_gnt1 ? bus.m1_addr  : bus.m0_addr;
                r_wdata      <= w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
            end
        end
    end

    // Per-master read data holds until that master's next rvalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m0_rdata <= {DATA_W{1'b0}};
            r_m1_rdata <= {DATA_W{1'b0}};
        end else if (r_state == ARB_READ_WAIT) begin
            if (r_owner) begin
                r_m1_rdata <= bus.ram_rdata;
            end else begin
                r_m0_rdata <= bus.ram_rdata;
            end
        end
    end

    // Bus outputs; RAM address/data simply follow the latch, so they hold outside ACCESS.
    always_comb begin
        bus.m0_gnt    = w_gnt0;
        bus.m1_gnt    = w_gnt1;
        bus.m0_rvalid = w_rd_valid && !r_owner;
        bus.m1_rvalid = w_rd_valid && r_owner;
        if (w_rd_valid && !r_owner) begin
            bus.m0_rdata = bus.ram_rdata;
        end else begin
            bus.m0_rdata = r_m0_rdata;
        end
        if (w_rd_valid && r_owner) begin
            bus.m1_rdata = bus.ram_rdata;
        end else begin
            bus.m1_rdata = r_m1_rdata;
        end
        bus.ram_we    = (r_state == ARB_ACCESS) && r_we && !reset;
        bus.ram_addr  = r_addr;
        bus.ram_wdata = r_wdata;
        busy          = (r_state != ARB_IDLE);
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one round-robin and one fixed-priority
// instance, each with a small synchronous RAM model.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic init_ram;
    logic busy_rr;
    logic busy_fx;
    int   total = 0;
    int   bad   = 0;
    int   cnt0;
    int   cnt1;
    logic found;
    logic got;

    logic [7:0] mem_rr [0:255];
    logic [7:0] mem_fx [0:255];

    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus_rr ();
    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus_fx ();

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .ARB_MODE(ARB_RR)) u_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_rr),
        .busy  (busy_rr)
    );

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .ARB_MODE(ARB_FIXED)) u_fx (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_fx),
        .busy  (busy_fx)
    );

    always #5 clk = ~clk;

    // Synchronous RAM models, one-cycle read latency.
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 256; i++) begin
                mem_rr[i] <= 8'h00;
                mem_fx[i] <= 8'h00;
            end
            mem_rr[1] <= 8'h11;
            mem_rr[2] <= 8'h22;
            mem_fx[1] <= 8'h11;
            mem_fx[2] <= 8'h22;
        end else begin
            if (bus_rr.ram_we) mem_rr[bus_rr.ram_addr[7:0]] <= bus_rr.ram_wdata;
            if (bus_fx.ram_we) mem_fx[bus_fx.ram_addr[7:0]] <= bus_fx.ram_wdata;
        end
        bus_rr.ram_rdata <= mem_rr[bus_rr.ram_addr[7:0]];
        bus_fx.ram_rdata <= mem_fx[bus_fx.ram_addr[7:0]];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        init_ram = 1'b1;
        bus_rr.m0_req = 1'b0; bus_rr.m0_we = 1'b0; bus_rr.m0_addr = 16'h0000; bus_rr.m0_wdata = 8'h00;
        bus_rr.m1_req = 1'b0; bus_rr.m1_we = 1'b0; bus_rr.m1_addr = 16'h0000; bus_rr.m1_wdata = 8'h00;
        bus_fx.m0_req = 1'b0; bus_fx.m0_we = 1'b0; bus_fx.m0_addr = 16'h0000; bus_fx.m0_wdata = 8'h00;
        bus_fx.m1_req = 1'b0; bus_fx.m1_we = 1'b0; bus_fx.m1_addr = 16'h0000; bus_fx.m1_wdata = 8'h00;
        repeat (2) @(posedge clk);

        // Reset values
        tick(); reset = 1'b0; init_ram = 1'b0; #1;
        chk("rst_busy", busy_rr, 1'b0);
        chk("rst_m0_gnt", bus_rr.m0_gnt, 1'b0);
        chk("rst_m1_gnt", bus_rr.m1_gnt, 1'b0);
        chk("rst_m0_rvalid", bus_rr.m0_rvalid, 1'b0);
        chk("rst_m1_rvalid", bus_rr.m1_rvalid, 1'b0);
        chk("rst_ram_we", bus_rr.ram_we, 1'b0);
        chk("rst_ram_addr", bus_rr.ram_addr, 16'h0000);
        chk("rst_ram_wdata", bus_rr.ram_wdata, 8'h00);
        chk("rst_m0_rdata", bus_rr.m0_rdata, 8'h00);
        chk("rst_m1_rdata", bus_rr.m1_rdata, 8'h00);
        chk("rst_fx_busy", busy_fx, 1'b0);

        // m0 writes A5 to 0010, then reads it back
        tick(); bus_rr.m0_req = 1'b1; bus_rr.m0_we = 1'b1; bus_rr.m0_addr = 16'h0010; bus_rr.m0_wdata = 8'hA5; #1;
        chk("wr_m0_gnt", bus_rr.m0_gnt, 1'b1);
        chk("wr_m1_gnt", bus_rr.m1_gnt, 1'b0);
        chk("wr_idle_we", bus_rr.ram_we, 1'b0);
        tick(); bus_rr.m0_req = 1'b0; #1;
        chk("wr_acc_busy", busy_rr, 1'b1);
        chk("wr_acc_we", bus_rr.ram_we, 1'b1);
        chk("wr_acc_addr", bus_rr.ram_addr, 16'h0010);
        chk("wr_acc_wdata", bus_rr.ram_wdata, 8'hA5);
        chk("wr_acc_gnt", bus_rr.m0_gnt, 1'b0);
        tick(); bus_rr.m0_req = 1'b1; bus_rr.m0_we = 1'b0; bus_rr.m0_addr = 16'h0010; #1;
        chk("wr_done_we", bus_rr.ram_we, 1'b0);
        chk("wr_done_busy", busy_rr, 1'b0);
        chk("wr_no_rvalid", bus_rr.m0_rvalid, 1'b0);
        chk("wr_mem", mem_rr[8'h10], 8'hA5);
        chk("rd_m0_gnt", bus_rr.m0_gnt, 1'b1);
        tick(); bus_rr.m0_req = 1'b0; #1;
        chk("rd_acc_busy", busy_rr, 1'b1);
        chk("rd_acc_we", bus_rr.ram_we, 1'b0);
        chk("rd_acc_rvalid", bus_rr.m0_rvalid, 1'b0);
        tick(); #1;
        chk("rd_rvalid", bus_rr.m0_rvalid, 1'b1);
        chk("rd_rdata", bus_rr.m0_rdata, 8'hA5);
        chk("rd_m1_rvalid", bus_rr.m1_rvalid, 1'b0);
        tick(); #1;
        chk("rd_rvalid_end", bus_rr.m0_rvalid, 1'b0);
        chk("rd_rdata_hold", bus_rr.m0_rdata, 8'hA5);
        chk("rd_busy_end", busy_rr, 1'b0);

        // Round-robin tie after reset: m0 first, then m1, then strict alternation
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        tick();
        bus_rr.m0_req = 1'b1; bus_rr.m0_we = 1'b0; bus_rr.m0_addr = 16'h0001;
        bus_rr.m1_req = 1'b1; bus_rr.m1_we = 1'b0; bus_rr.m1_addr = 16'h0002; #1;
        chk("rr_tie_m0", bus_rr.m0_gnt, 1'b1);
        chk("rr_tie_m1", bus_rr.m1_gnt, 1'b0);
        tick(); bus_rr.m0_req = 1'b0; #1;
        chk("rr_acc_m1_wait", bus_rr.m1_gnt, 1'b0);
        chk("rr_acc_busy", busy_rr, 1'b1);
        chk("rr_acc_addr", bus_rr.ram_addr, 16'h0001);
        tick(); #1;
        chk("rr_m0_rvalid", bus_rr.m0_rvalid, 1'b1);
        chk("rr_m0_rdata", bus_rr.m0_rdata, 8'h11);
        chk("rr_m1_rvalid", bus_rr.m1_rvalid, 1'b0);
        chk("rr_rw_m1_wait", bus_rr.m1_gnt, 1'b0);
        tick(); bus_rr.m0_req = 1'b1; #1;
        chk("rr_second_m1", bus_rr.m1_gnt, 1'b1);
        chk("rr_second_m0", bus_rr.m0_gnt, 1'b0);
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            got   = 1'b0;
            for (int c = 0; c < 6 && !found; c++) begin
                tick(); #1;
                if (bus_rr.m0_gnt || bus_rr.m1_gnt) begin
                    found = 1'b1;
                    got   = bus_rr.m1_gnt;
                    chk("rr_onehot", {bus_rr.m0_gnt, bus_rr.m1_gnt} == 2'b11, 1'b0);
                end
            end
            chk("rr_found", found, 1'b1);
            chk("rr_order", got, k[0]);
        end
        tick(); bus_rr.m0_req = 1'b0; bus_rr.m1_req = 1'b0;
        tick();
        tick(); #1;
        chk("rr_drain_busy", busy_rr, 1'b0);

        // m1 writes 3C to 0020; m0 read of 0020 arrives one cycle later and must wait
        tick(); bus_rr.m1_req = 1'b1; bus_rr.m1_we = 1'b1; bus_rr.m1_addr = 16'h0020; bus_rr.m1_wdata = 8'h3C; #1;
        chk("wr1_m1_gnt", bus_rr.m1_gnt, 1'b1);
        tick(); bus_rr.m1_req = 1'b0; bus_rr.m0_req = 1'b1; bus_rr.m0_we = 1'b0; bus_rr.m0_addr = 16'h0020; #1;
        chk("wr1_busy", busy_rr, 1'b1);
        chk("wr1_m0_wait", bus_rr.m0_gnt, 1'b0);
        chk("wr1_we", bus_rr.ram_we, 1'b1);
        tick(); #1;
        chk("wr1_m0_gnt", bus_rr.m0_gnt, 1'b1);
        tick(); bus_rr.m0_req = 1'b0; #1;
        chk("wr1_rd_busy", busy_rr, 1'b1);
        tick(); #1;
        chk("wr1_rvalid", bus_rr.m0_rvalid, 1'b1);
        chk("wr1_rdata", bus_rr.m0_rdata, 8'h3C);
        chk("wr1_m1_rvalid", bus_rr.m1_rvalid, 1'b0);
        tick();

        // Reset during READ_WAIT drops the read
        tick(); bus_rr.m0_req = 1'b1; bus_rr.m0_we = 1'b0; bus_rr.m0_addr = 16'h0001; #1;
        chk("rrst_gnt", bus_rr.m0_gnt, 1'b1);
        tick(); bus_rr.m0_req = 1'b0;
        tick(); reset = 1'b1; #1;
        chk("rrst_no_rvalid", bus_rr.m0_rvalid, 1'b0);
        chk("rrst_no_rvalid1", bus_rr.m1_rvalid, 1'b0);
        chk("rrst_rdata_hold", bus_rr.m0_rdata, 8'h3C);
        tick(); reset = 1'b0;
        bus_rr.m0_req = 1'b1; bus_rr.m0_we = 1'b0; bus_rr.m0_addr = 16'h0001;
        bus_rr.m1_req = 1'b1; bus_rr.m1_we = 1'b0; bus_rr.m1_addr = 16'h0002; #1;
        chk("rrst_busy", busy_rr, 1'b0);
        chk("rrst_rdata", bus_rr.m0_rdata, 8'h00);
        chk("rrst_ram_addr", bus_rr.ram_addr, 16'h0000);
        chk("rrst_ram_wdata", bus_rr.ram_wdata, 8'h00);
        chk("rrst_ram_we", bus_rr.ram_we, 1'b0);
        chk("rrst_rvalid", bus_rr.m0_rvalid, 1'b0);
        chk("rrst_tie_m0", bus_rr.m0_gnt, 1'b1);
        chk("rrst_tie_m1", bus_rr.m1_gnt, 1'b0);
        tick(); bus_rr.m0_req = 1'b0; bus_rr.m1_req = 1'b0;
        tick(); #1;
        chk("rrst_rd_rvalid", bus_rr.m0_rvalid, 1'b1);
        chk("rrst_rd_rdata", bus_rr.m0_rdata, 8'h11);
        tick(); #1;
        chk("rrst_idle", busy_rr, 1'b0);
        chk("rrst_m1_dropped", bus_rr.m1_gnt, 1'b0);

        // Reset in ACCESS suppresses the write
        tick(); bus_rr.m0_req = 1'b1; bus_rr.m0_we = 1'b1; bus_rr.m0_addr = 16'h0030; bus_rr.m0_wdata = 8'h55; #1;
        chk("wrst_gnt", bus_rr.m0_gnt, 1'b1);
        tick(); bus_rr.m0_req = 1'b0; reset = 1'b1; #1;
        chk("wrst_we", bus_rr.ram_we, 1'b0);
        tick(); reset = 1'b0; bus_rr.m0_req = 1'b1; bus_rr.m0_we = 1'b0; bus_rr.m0_addr = 16'h0030; #1;
        chk("wrst_busy", busy_rr, 1'b0);
        chk("wrst_mem", mem_rr[8'h30], 8'h00);
        chk("wrst_rd_gnt", bus_rr.m0_gnt, 1'b1);
        tick(); bus_rr.m0_req = 1'b0;
        tick(); #1;
        chk("wrst_rvalid", bus_rr.m0_rvalid, 1'b1);
        chk("wrst_rdata", bus_rr.m0_rdata, 8'h00);

        // Fixed priority: both saturate for 20 cycles, m1 never granted
        tick();
        bus_fx.m0_req = 1'b1; bus_fx.m0_we = 1'b0; bus_fx.m0_addr = 16'h0001;
        bus_fx.m1_req = 1'b1; bus_fx.m1_we = 1'b0; bus_fx.m1_addr = 16'h0002;
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus_fx.m0_gnt) cnt0++;
            if (bus_fx.m1_gnt) cnt1++;
            tick();
        end
        bus_fx.m0_req = 1'b0; #1;
        chk("fx_m1_never", cnt1, 0);
        chk("fx_m0_count", cnt0, 7);
        chk("fx_rw_m1_wait", bus_fx.m1_gnt, 1'b0);
        chk("fx_rw_busy", busy_fx, 1'b1);
        chk("fx_m0_rvalid", bus_fx.m0_rvalid, 1'b1);
        chk("fx_m0_rdata", bus_fx.m0_rdata, 8'h11);
        tick(); #1;
        chk("fx_m1_gnt", bus_fx.m1_gnt, 1'b1);
        chk("fx_m0_gnt", bus_fx.m0_gnt, 1'b0);
        tick(); bus_fx.m1_req = 1'b0;
        tick(); #1;
        chk("fx_m1_rvalid", bus_fx.m1_rvalid, 1'b1);
        chk("fx_m1_rdata", bus_fx.m1_rdata, 8'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
